// File: rtl/iram_port_arbiter.sv
// Arbitrates a single-port iRAM between CPU fetches (READ_LATENCY+2 cycles to fetch_valid) and loader writes (data_ack 2 cycles after grant).
// No pre-emption: requests that arrive mid-transaction are held off until IDLE; a starved loader eventually wins over fetches.
module iram_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_paused,
    input  logic        fetch_req,
    input  logic [7:0]  fetch_addr,
    output logic        fetch_valid,
    output logic [23:0] fetch_data,
    input  logic        loader_we,
    input  logic [7:0]  loader_addr,
    input  logic [23:0] loader_data,
    output logic        data_ack,
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [23:0] ram_wdata,
    input  logic [23:0] ram_rdata,
    output logic [7:0]  write_count
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_WAIT,
        WRITE,
        ACK,
        COOL
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [1:0] WAIT_LAST  = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [1:0]  wait_q, wait_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wcount_q, wcount_d;
    logic [23:0] fdata_q, fdata_d;
    logic        fvalid_q, fvalid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            wait_q   <= 2'd0;
            addr_q   <= 8'd0;
            wcount_q <= 8'd0;
            fdata_q  <= 24'd0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wcount_q <= wcount_d;
            fdata_q  <= fdata_d;
            fvalid_q <= fvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        wcount_d  = wcount_q;
        fdata_d   = fdata_q;
        fvalid_d  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 8'd0;
        ram_wdata = 24'd0;
        data_ack  = 1'b0;

        case (state_q)
            IDLE: begin
                // While the loader holds the CPU, fetches are not even considered.
                if (cpu_paused) begin
                    if (loader_we) begin
                        state_d  = WRITE;
                        starve_d = 4'd0;
                    end
                end else if (fetch_req && loader_we && (starve_q == STARVE_MAX)) begin
                    state_d  = WRITE;
                    starve_d = 4'd0;
                end else if (fetch_req) begin
                    state_d = READ;
                    addr_d  = fetch_addr;
                    if (loader_we && (starve_q < STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (loader_we) begin
                    state_d  = WRITE;
                    starve_d = 4'd0;
                end
            end
            READ: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
                wait_d   = 2'd0;
                state_d  = READ_WAIT;
            end
            READ_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    fdata_d  = ram_rdata;
                    fvalid_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            WRITE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = loader_addr;
                ram_wdata = loader_data;
                wcount_d  = wcount_q + 8'd1;
                state_d   = ACK;
            end
            ACK: begin
                data_ack = 1'b1;
                state_d  = COOL;
            end
            COOL: begin
                // Gives the loader a cycle to drop loader_we after data_ack.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_valid = fvalid_q;
    assign fetch_data  = fdata_q;
    assign write_count = wcount_q;

endmodule

// File: tb/tb_iram_port_arbiter.sv
module tb_iram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_paused, fetch_req, loader_we;
    logic [7:0]  fetch_addr, loader_addr;
    logic [23:0] loader_data;
    logic        fetch_valid, data_ack, ram_en, ram_we;
    logic [23:0] fetch_data, ram_wdata, ram_rdata;
    logic [7:0]  ram_addr, write_count;

    logic        f3_req;
    logic [7:0]  f3_addr;
    logic        fetch_valid3, data_ack3, ram_en3, ram_we3;
    logic [23:0] fetch_data3, ram_wdata3, ram_rdata3;
    logic [7:0]  ram_addr3, write_count3;

    int tests = 0;
    int fails = 0;
    logic [7:0]  exp_wc = 8'd0;
    logic [23:0] exp_q[$];

    iram_port_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .cpu_paused(cpu_paused),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .loader_we(loader_we), .loader_addr(loader_addr), .loader_data(loader_data),
        .data_ack(data_ack), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .write_count(write_count)
    );

    iram_port_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst), .cpu_paused(1'b0),
        .fetch_req(f3_req), .fetch_addr(f3_addr),
        .fetch_valid(fetch_valid3), .fetch_data(fetch_data3),
        .loader_we(1'b0), .loader_addr(8'd0), .loader_data(24'd0),
        .data_ack(data_ack3), .ram_en(ram_en3), .ram_we(ram_we3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3),
        .write_count(write_count3)
    );

    // RAM models: latency 1 for dut, 3-stage read pipeline for dut3
    logic [23:0] mem1 [256];
    logic [23:0] mem3 [256];
    logic [23:0] rd1, r3a, r3b, r3c;

    always @(posedge clk) begin
        if (!rst) begin
            mem1[8'h10] <= 24'hABCDEF;
            mem1[8'h05] <= 24'h000000;
        end else begin
            if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
            if (ram_en && !ram_we) rd1 <= mem1[ram_addr];
        end
    end
    assign ram_rdata = rd1;

    always @(posedge clk) begin
        if (!rst) begin
            mem3[8'h42] <= 24'h5A5A5A;
        end else begin
            if (ram_en3 && !ram_we3) r3a <= mem3[ram_addr3];
            r3b <= r3a;
            r3c <= r3b;
        end
    end
    assign ram_rdata3 = r3c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL timeout: simulation did not reach the end, observed running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every fetch_valid pops one expected word
    always @(negedge clk) begin
        if (rst && fetch_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_unexpected observed=%h expected=none", fetch_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                assert (fetch_data === e) else begin
                    fails++;
                    $error("FAIL sb_fetch_data observed=%h expected=%h", fetch_data, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [23:0] d);
        bit got;
        got = 0;
        cpu_paused  = 1'b1;
        loader_we   = 1'b1;
        loader_addr = a;
        loader_data = d;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (data_ack) got = 1;
        end
        loader_we = 1'b0;
        exp_wc = exp_wc + 8'd1;
        check("wr_count", {24'd0, write_count}, {24'd0, exp_wc});
        step();
        step();
    endtask

    task automatic contention(input logic [23:0] wd, output int nf);
        bit done;
        bit wrote;
        done  = 0;
        wrote = 0;
        nf    = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(24'h123456);
        cpu_paused  = 1'b0;
        fetch_req   = 1'b1;
        fetch_addr  = 8'h05;
        loader_we   = 1'b1;
        loader_addr = 8'h06;
        loader_data = wd;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (ram_en && !ram_we && !wrote) nf++;
            if (ram_en && ram_we) begin
                wrote = 1;
                check("cont_wdata", {8'd0, ram_wdata}, {8'd0, wd});
            end
            if (data_ack) begin
                loader_we = 1'b0;
                fetch_req = 1'b0;
                done = 1;
            end
        end
        check("cont_ack_seen", {31'd0, done}, 32'd1);
        exp_wc = exp_wc + 8'd1;
        check("cont_wcount", {24'd0, write_count}, {24'd0, exp_wc});
        step();
        step();
    endtask

    initial begin
        int cnt;
        int nf;
        rst = 1'b0;
        cpu_paused = 1'b0; fetch_req = 1'b0; fetch_addr = 8'd0;
        loader_we = 1'b0; loader_addr = 8'd0; loader_data = 24'd0;
        f3_req = 1'b0; f3_addr = 8'd0;

        #2;
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_data_ack",    {31'd0, data_ack},    32'd0);
        check("rst_ram_en",      {31'd0, ram_en},      32'd0);
        check("rst_ram_we",      {31'd0, ram_we},      32'd0);
        check("rst_ram_addr",    {24'd0, ram_addr},    32'd0);
        check("rst_ram_wdata",   {8'd0, ram_wdata},    32'd0);
        check("rst_write_count", {24'd0, write_count}, 32'd0);
        check("rst_fetch_data",  {8'd0, fetch_data},   32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // Read latency 3
        f3_addr = 8'h42;
        f3_req  = 1'b1;
        cnt = 0;
        while (!fetch_valid3 && cnt < 20) begin
            step();
            cnt++;
            if (cnt == 1) f3_req = 1'b0;
        end
        check("rl3_latency", cnt, 32'd5);
        check("rl3_data", {8'd0, fetch_data3}, 32'h005A5A5A);
        step();

        // Basic fetch, request dropped right after grant
        fetch_addr = 8'h10;
        fetch_req  = 1'b1;
        exp_q.push_back(24'hABCDEF);
        step();
        check("f_ram_en",   {31'd0, ram_en}, 32'd1);
        check("f_ram_we",   {31'd0, ram_we}, 32'd0);
        check("f_ram_addr", {24'd0, ram_addr}, 32'h10);
        fetch_req = 1'b0;
        step();
        check("f_ram_en_once", {31'd0, ram_en}, 32'd0);
        check("f_valid_early", {31'd0, fetch_valid}, 32'd0);
        step();
        check("f_valid_cyc3", {31'd0, fetch_valid}, 32'd1);
        check("f_data",       {8'd0, fetch_data}, 32'h00ABCDEF);
        step();
        check("f_valid_pulse", {31'd0, fetch_valid}, 32'd0);
        check("f_data_hold",   {8'd0, fetch_data}, 32'h00ABCDEF);

        // Loader write while paused
        cpu_paused  = 1'b1;
        loader_we   = 1'b1;
        loader_addr = 8'h05;
        loader_data = 24'h123456;
        step();
        check("w_ram_en",    {31'd0, ram_en}, 32'd1);
        check("w_ram_we",    {31'd0, ram_we}, 32'd1);
        check("w_ram_addr",  {24'd0, ram_addr}, 32'h05);
        check("w_ram_wdata", {8'd0, ram_wdata}, 32'h00123456);
        check("w_no_ack",    {31'd0, data_ack}, 32'd0);
        step();
        exp_wc = exp_wc + 8'd1;
        check("w_ack",       {31'd0, data_ack}, 32'd1);
        check("w_ack_no_we", {31'd0, ram_we}, 32'd0);
        check("w_count1",    {24'd0, write_count}, {24'd0, exp_wc});
        loader_we = 1'b0;
        step();
        check("w_ack_pulse", {31'd0, data_ack}, 32'd0);
        step();

        // Contention: two rounds show the starve counter is cleared by the write
        contention(24'h654321, nf);
        check("cont1_fetches", nf, 32'd4);
        contention(24'h0A0B0C, nf);
        check("cont2_fetches", nf, 32'd4);

        // No pre-emption; pause rising mid-read still completes the fetch
        cpu_paused = 1'b0;
        fetch_addr = 8'h10;
        fetch_req  = 1'b1;
        exp_q.push_back(24'hABCDEF);
        step();
        cpu_paused  = 1'b1;
        fetch_req   = 1'b0;
        loader_we   = 1'b1;
        loader_addr = 8'h07;
        loader_data = 24'h0F0F0F;
        check("pe_read_no_we", {31'd0, ram_we}, 32'd0);
        step();
        check("pe_wait_no_en", {31'd0, ram_en}, 32'd0);
        step();
        check("pe_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        step();
        check("pe_write_after", {31'd0, ram_we}, 32'd1);
        step();
        exp_wc = exp_wc + 8'd1;
        check("pe_ack", {31'd0, data_ack}, 32'd1);
        check("pe_count", {24'd0, write_count}, {24'd0, exp_wc});
        loader_we = 1'b0;
        step(); step();

        // Paused fetch is ignored
        cpu_paused = 1'b1;
        fetch_req  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ram_en || fetch_valid) cnt++;
        end
        check("paused_no_access", cnt, 32'd0);
        fetch_req = 1'b0;

        // Count wraps to zero after 256 writes since reset
        while (exp_wc != 8'd0) do_write(8'hF0, {16'd0, exp_wc});
        check("wrap_zero", {24'd0, write_count}, 32'd0);

        // Asynchronous reset in the middle of WRITE
        cpu_paused  = 1'b1;
        loader_we   = 1'b1;
        loader_addr = 8'h33;
        loader_data = 24'h777777;
        step();
        check("rw_in_write", {31'd0, ram_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_wc = 8'd0;
        check("rw_ram_en",     {31'd0, ram_en}, 32'd0);
        check("rw_ram_we",     {31'd0, ram_we}, 32'd0);
        check("rw_ram_addr",   {24'd0, ram_addr}, 32'd0);
        check("rw_ram_wdata",  {8'd0, ram_wdata}, 32'd0);
        check("rw_data_ack",   {31'd0, data_ack}, 32'd0);
        check("rw_fetch_data", {8'd0, fetch_data}, 32'd0);
        check("rw_count",      {24'd0, write_count}, 32'd0);
        step();
        check("rw_held_no_ack", {31'd0, data_ack}, 32'd0);
        rst = 1'b1;
        step();
        check("rw_first_grant", {31'd0, ram_we}, 32'd1);
        check("rw_grant_addr",  {24'd0, ram_addr}, 32'h33);
        step();
        exp_wc = exp_wc + 8'd1;
        check("rw_ack", {31'd0, data_ack}, 32'd1);
        check("rw_count1", {24'd0, write_count}, {24'd0, exp_wc});
        loader_we = 1'b0;
        step(); step();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
